// File: rtl/spi_slave_if.sv
// IO-bus, interrupt and SPI pin bundle for the SPI slave peripheral.
// The slave modport is the peripheral's view; master is the CPU/external-master side.
interface spi_slave_if;
   logic [5:0] io_a;
   logic       io_we;
   logic       io_re;
   logic [7:0] io_di;
   logic [7:0] io_do;
   logic       spi_irq;
   logic       spi_irq_ack;
   logic       spi_sck;
   logic       spi_ss_n;
   logic       spi_mosi;
   logic       spi_miso;
   logic       spi_miso_oe;

   modport slave (
      input  io_a, io_we, io_re, io_di, spi_irq_ack, spi_sck, spi_ss_n, spi_mosi,
      output io_do, spi_irq, spi_miso, spi_miso_oe
   );

   modport master (
      output io_a, io_we, io_re, io_di, spi_irq_ack, spi_sck, spi_ss_n, spi_mosi,
      input  io_do, spi_irq, spi_miso, spi_miso_oe
   );
endinterface

// File: rtl/spi_slave.sv
// IO-mapped SPI slave: oversamples SCK/SS_n/MOSI, shifts MSB first in all four
// CPOL/CPHA modes, and raises a byte-complete interrupt.
module spi_slave #(
   parameter logic [5:0] base_addr = 6'h19
) (
   input logic        sys_clk,
   input logic        sys_rst,
   spi_slave_if.slave bus
);

   localparam logic [5:0] ssdr_addr = base_addr;
   localparam logic [5:0] sscr_addr = base_addr + 6'd1;
   localparam logic [5:0] sssr_addr = base_addr + 6'd2;

   typedef enum logic [0:0] {st_idle = 1'b0, st_active = 1'b1} state_t;

   state_t     state_r;
   state_t     state_next_s;

   logic       sck_q1_r, sck_q2_r, sck_q3_r;
   logic       ss_q1_r, ss_q2_r, ss_q3_r;
   logic       mosi_q1_r, mosi_q2_r;

   logic [7:0] sscr_r;
   logic [7:0] tx_buf_r;
   logic [7:0] rx_buf_r;
   logic [7:0] tx_sh_r;
   logic [7:0] rx_sh_r;
   logic [2:0] bit_cnt_r;
   logic       ssif_r;
   logic       ovr_r;
   logic       txe_r;
   logic       busy_r;
   logic       reload_r;
   logic [7:0] io_do_r;
   logic       miso_oe_r;

   logic       sse_s, ssie_s, cpol_s, cpha_s;
   logic       sck_rise_s, sck_fall_s, ss_fall_s;
   logic       lead_s, trail_s, sample_s, shift_s;
   logic       enter_s, leave_s, run_s;
   logic       wr_ssdr_s, wr_sscr_s;
   logic       rd_ssdr_s, rd_sscr_s, rd_sssr_s;
   logic [7:0] status_s;

   assign ssie_s = sscr_r[7];
   assign sse_s  = sscr_r[6];
   assign cpol_s = sscr_r[3];
   assign cpha_s = sscr_r[2];

   assign sck_rise_s = sck_q2_r & ~sck_q3_r;
   assign sck_fall_s = ~sck_q2_r & sck_q3_r;
   assign ss_fall_s  = ~ss_q2_r & ss_q3_r;
   // lead moves away from the CPOL idle level, trail returns to it
   assign lead_s     = cpol_s ? sck_fall_s : sck_rise_s;
   assign trail_s    = cpol_s ? sck_rise_s : sck_fall_s;
   assign sample_s   = cpha_s ? trail_s : lead_s;
   assign shift_s    = cpha_s ? lead_s : trail_s;

   assign enter_s = (state_r == st_idle)   && (state_next_s == st_active);
   assign leave_s = (state_r == st_active) && (state_next_s == st_idle);
   assign run_s   = (state_r == st_active) && (state_next_s == st_active);

   assign wr_ssdr_s = bus.io_we && (bus.io_a == ssdr_addr);
   assign wr_sscr_s = bus.io_we && (bus.io_a == sscr_addr);
   assign rd_ssdr_s = bus.io_re && (bus.io_a == ssdr_addr);
   assign rd_sscr_s = bus.io_re && (bus.io_a == sscr_addr);
   assign rd_sssr_s = bus.io_re && (bus.io_a == sssr_addr);

   assign status_s = {ssif_r, ovr_r, txe_r, 4'b0000, busy_r};

   // Pin synchronizers; third stage on sck/ss_n for edge detection
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sck_q1_r  <= 1'b0;
         sck_q2_r  <= 1'b0;
         sck_q3_r  <= 1'b0;
         ss_q1_r   <= 1'b1;
         ss_q2_r   <= 1'b1;
         ss_q3_r   <= 1'b1;
         mosi_q1_r <= 1'b0;
         mosi_q2_r <= 1'b0;
      end else begin
         sck_q1_r  <= bus.spi_sck;
         sck_q2_r  <= sck_q1_r;
         sck_q3_r  <= sck_q2_r;
         ss_q1_r   <= bus.spi_ss_n;
         ss_q2_r   <= ss_q1_r;
         ss_q3_r   <= ss_q2_r;
         mosi_q1_r <= bus.spi_mosi;
         mosi_q2_r <= mosi_q1_r;
      end
   end

   // FSM state register
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_r <= st_idle;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state: select/enable gate the transfer
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         st_idle: begin
            if (sse_s && ss_fall_s) state_next_s = st_active;
            else                    state_next_s = st_idle;
         end
         st_active: begin
            if (!sse_s || ss_q2_r) state_next_s = st_idle;
            else                   state_next_s = st_active;
         end
         default: state_next_s = st_idle;
      endcase
   end

   // Registers, shifters and status flags
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sscr_r    <= 8'h00;
         tx_buf_r  <= 8'h00;
         rx_buf_r  <= 8'h00;
         tx_sh_r   <= 8'h00;
         rx_sh_r   <= 8'h00;
         bit_cnt_r <= 3'd0;
         ssif_r    <= 1'b0;
         ovr_r     <= 1'b0;
         txe_r     <= 1'b1;
         busy_r    <= 1'b0;
         reload_r  <= 1'b0;
      end else begin
         if (wr_sscr_s) sscr_r <= bus.io_di & 8'hCC;
         // clear first so a simultaneous byte-complete below wins
         if (rd_sssr_s || bus.spi_irq_ack) begin
            ssif_r <= 1'b0;
            ovr_r  <= 1'b0;
         end
         if (enter_s) begin
            tx_sh_r   <= tx_buf_r;
            txe_r     <= 1'b1;
            bit_cnt_r <= 3'd0;
            reload_r  <= 1'b0;
            busy_r    <= 1'b1;
         end else if (leave_s) begin
            busy_r    <= 1'b0;
            bit_cnt_r <= 3'd0;
            reload_r  <= 1'b0;
         end else if (run_s) begin
            if (sample_s) begin
               rx_sh_r   <= {rx_sh_r[6:0], mosi_q2_r};
               bit_cnt_r <= bit_cnt_r + 3'd1;
               if (bit_cnt_r == 3'd7) begin
                  rx_buf_r <= {rx_sh_r[6:0], mosi_q2_r};
                  ssif_r   <= 1'b1;
                  reload_r <= 1'b1;
                  if (ssif_r) ovr_r <= 1'b1;
               end
            end
            if (shift_s) begin
               if (reload_r) begin
                  tx_sh_r  <= tx_buf_r;
                  txe_r    <= 1'b1;
                  reload_r <= 1'b0;
               end else if (cpha_s && (bit_cnt_r == 3'd0)) begin
                  tx_sh_r <= tx_sh_r;
               end else begin
                  tx_sh_r <= {tx_sh_r[6:0], 1'b0};
               end
            end
         end
         if (wr_ssdr_s) begin
            tx_buf_r <= bus.io_di;
            txe_r    <= 1'b0;
         end
      end
   end

   // Registered read port and MISO enable
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         io_do_r   <= 8'h00;
         miso_oe_r <= 1'b0;
      end else begin
         if (rd_ssdr_s)      io_do_r <= rx_buf_r;
         else if (rd_sscr_s) io_do_r <= sscr_r;
         else if (rd_sssr_s) io_do_r <= status_s;
         else                io_do_r <= 8'h00;
         miso_oe_r <= sse_s & ~ss_q2_r;
      end
   end

   assign bus.io_do       = io_do_r;
   assign bus.spi_miso    = tx_sh_r[7];
   assign bus.spi_miso_oe = miso_oe_r;
   assign bus.spi_irq     = ssie_s & ssif_r;

endmodule
